pipelined_adder: RTL

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_pkg.sv | 13 +
 rtl/adder_stage.sv | 42 ++++
 rtl/pipelined_adder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the chunked, carry-pipelined adder.
package pipelined_adder_pkg;

    localparam int unsigned DefaultWidth  = 32;
    localparam int unsigned DefaultStages = 4;

    // Bits handled per pipeline stage; a zero stage count is caught by the top's check.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? 1 : width / stages;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One chunk of the pipelined adder: CHUNK-bit add with carry-in, registered sum/carry/overflow.
module adder_stage #(
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [CHUNK-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;

    always_comb begin
        {cout_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
        // Carry into the top bit is recovered from sum ^ a ^ b at that bit.
        ovf_d = cout_d ^ sum_d[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (en_i) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder: STAGES chunks, operand skew in, result de-skew out, valid/ready flow.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned STAGES = DefaultStages
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $fatal(1, "pipelined_adder: need WIDTH %% STAGES == 0 and 1 <= STAGES <= WIDTH");
    end

    logic              advance;
    logic [STAGES-1:0] valid_d, valid_q;
    logic [STAGES-1:0] carry;
    logic [CHUNK-1:0]  stage_sum [STAGES];

    // The whole pipe moves as one; a stalled output freezes every register.
    assign out_valid = valid_q[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign cout      = carry[STAGES-1];

    if (STAGES > 1) begin : g_valid_shift
        always_comb valid_d = {valid_q[STAGES-2:0], in_valid};
    end else begin : g_valid_single
        always_comb valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= valid_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] a_op, b_op;
        logic             c_op;
        logic             ovf_k;

        if (k == 0) begin : g_head
            assign a_op = a[CHUNK-1:0];
            assign b_op = b[CHUNK-1:0];
            assign c_op = cin;
        end else begin : g_skew
            // Chunk k waits k levels so it meets the carry from chunk k-1.
            logic [CHUNK-1:0] a_dly_d [k];
            logic [CHUNK-1:0] a_dly_q [k];
            logic [CHUNK-1:0] b_dly_d [k];
            logic [CHUNK-1:0] b_dly_q [k];

            always_comb begin
                a_dly_d[0] = a[k*CHUNK +: CHUNK];
                b_dly_d[0] = b[k*CHUNK +: CHUNK];
                for (int unsigned i = 1; i < k; i++) begin
                    a_dly_d[i] = a_dly_q[i-1];
                    b_dly_d[i] = b_dly_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    a_dly_q <= a_dly_d;
                    b_dly_q <= b_dly_d;
                end
            end

            assign a_op = a_dly_q[k-1];
            assign b_op = b_dly_q[k-1];
            assign c_op = carry[k-1];
        end

        adder_stage #(
            .CHUNK(CHUNK)
        ) u_stage (
            .clk_i (clk),
            .rst_i (rst),
            .en_i  (advance),
            .a_i   (a_op),
            .b_i   (b_op),
            .cin_i (c_op),
            .sum_o (stage_sum[k]),
            .cout_o(carry[k]),
            .ovf_o (ovf_k)
        );

        if (k == STAGES - 1) begin : g_tail
            assign sum[k*CHUNK +: CHUNK] = stage_sum[k];
            assign ovf = ovf_k;
        end else begin : g_align
            localparam int unsigned Depth = STAGES - 1 - k;
            logic [CHUNK-1:0] res_d [Depth];
            logic [CHUNK-1:0] res_q [Depth];
            logic             ovf_unused;

            assign ovf_unused = ovf_k;

            always_comb begin
                res_d[0] = stage_sum[k];
                for (int unsigned i = 1; i < Depth; i++) begin
                    res_d[i] = res_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    res_q <= '{default: '0};
                end else if (advance) begin
                    res_q <= res_d;
                end
            end

            assign sum[k*CHUNK +: CHUNK] = res_q[Depth-1];
        end
    end

endmodule
